clk_div_multi: RTL and testbench

//   N-channel programmable clock divider / tick generator. Each channel derives a

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_multi_if.sv | 32 +++
 rtl/clk_div_chan.sv | 71 +++++++
 rtl/clk_div_multi.sv | 49 ++++
 tb/tb_clk_div_multi.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared mode encoding, default sizing and select-width helper for the clock divider.
// Latency: n/a (definitions only); backpressure: n/a.
package clk_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 24;
  localparam logic [DEF_CNT_W-1:0] DEF_DIV_VAL = 24'd4_999_999;

  // Channel-select width, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of the multi-channel divider: run/mode controls, divisor write port, outputs.
// Latency: n/a (wiring only); backpressure: none, every signal is sampled or presented each cycle.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W
) ();

  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  mode;
  logic             sync;
  logic             div_we;
  logic [SEL_W-1:0] div_sel;
  logic [CNT_W-1:0] div_val;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  clkout;
  logic [N_CH-1:0]  tick;

  modport master (
    output en, mode, sync, div_we, div_sel, div_val,
    input  pend, clkout, tick
  );

  modport slave (
    input  en, mode, sync, div_we, div_sel, div_val,
    output pend, clkout, tick
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, toggle clock and terminal-count strobe.
// Latency: outputs registered, one clkin after the deciding edge; backpressure: none (free-running).
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_VAL)
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic             i_sync,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_div_val,
  output logic             o_pend,
  output logic             o_clkout,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_div_shadow;
  logic             r_pend;
  logic             r_clkout;
  logic             r_tick;

  logic             w_term;
  logic             w_restart;
  logic [CNT_W-1:0] w_next_div;

  assign w_term    = i_en && !i_sync && (r_cnt >= r_div_act);
  assign w_restart = i_sync || !i_en || w_term;

  // A write landing in an apply cycle bypasses the shadow, so it never shows as pending.
  assign w_next_div = i_we ? i_div_val : r_div_shadow;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_cnt        <= '0;
      r_div_act    <= DEF_DIV;
      r_div_shadow <= DEF_DIV;
      r_pend       <= 1'b0;
      r_clkout     <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      if (i_we) begin
        r_div_shadow <= i_div_val;
      end
      if (w_restart) begin
        r_cnt     <= '0;
        r_div_act <= w_next_div;
        r_pend    <= 1'b0;
        r_tick    <= w_term;
        // Mode is sampled only at terminal count; pulse mode parks the clock low there.
        r_clkout  <= w_term && (i_mode == MODE_TOGGLE) && !r_clkout;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
        if (i_we) begin
          r_pend <= 1'b1;
        end
      end
    end
  end

  assign o_pend   = r_pend;
  assign o_clkout = r_clkout;
  assign o_tick   = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider / tick generator with shadowed divisors and global realign.
// Latency: all outputs registered (1 clkin); backpressure: none, writes are always accepted.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               N_CH    = DEF_N_CH,
  parameter int               CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_DIV_VAL)
) (
  input logic            clkin,
  input logic            rstn,
  clk_div_multi_if.slave bus
);

  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH-1:0] w_pend;
  logic [N_CH-1:0] w_clkout;
  logic [N_CH-1:0] w_tick;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [SEL_W-1:0] CH_IDX = SEL_W'(i);

    // Selects beyond the last channel match no index and are dropped.
    logic w_we;
    assign w_we = bus.div_we && (bus.div_sel == CH_IDX);

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clkin     (clkin),
      .rstn      (rstn),
      .i_en      (bus.en[i]),
      .i_mode    (bus.mode[i]),
      .i_sync    (bus.sync),
      .i_we      (w_we),
      .i_div_val (bus.div_val),
      .o_pend    (w_pend[i]),
      .o_clkout  (w_clkout[i]),
      .o_tick    (w_tick[i])
    );
  end

  assign bus.pend   = w_pend;
  assign bus.clkout = w_clkout;
  assign bus.tick   = w_tick;

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised bench for clk_div_multi: a time-schedule reference model fills a scoreboard per cycle.
// A 4-channel and a 3-channel build share stimulus; the 3-channel one must ignore select 3.
module tb_clk_div_multi;

  localparam int N = 4;
  localparam int W = 8;
  localparam logic [W-1:0] DDIV = 8'd3;

  logic clkin = 1'b0;
  logic rstn  = 1'b1;
  always #5 clkin = ~clkin;

  clk_div_multi_if #(.N_CH(4), .CNT_W(W)) bus  ();
  clk_div_multi_if #(.N_CH(3), .CNT_W(W)) bus3 ();

  clk_div_multi #(.N_CH(4), .CNT_W(W), .DEF_DIV(DDIV)) u_dut (
    .clkin (clkin),
    .rstn  (rstn),
    .bus   (bus)
  );

  clk_div_multi #(.N_CH(3), .CNT_W(W), .DEF_DIV(DDIV)) u_dut3 (
    .clkin (clkin),
    .rstn  (rstn),
    .bus   (bus3)
  );

  assign bus3.en      = bus.en[2:0];
  assign bus3.mode    = bus.mode[2:0];
  assign bus3.sync    = bus.sync;
  assign bus3.div_we  = bus.div_we;
  assign bus3.div_sel = bus.div_sel;
  assign bus3.div_val = bus.div_val;

  int checks   = 0;
  int failures = 0;

  // Expected {pend[3:0], clkout[3:0], tick[3:0]} after each modelled edge.
  logic [11:0] sb[$];

  // Reference model: k counts clkin edges; due[c] is the edge index of channel c's next terminal count.
  int k;
  int m_due[N];
  int m_act[N];
  int m_sh[N];
  bit m_pend[N];
  bit m_clk[N];
  bit m_tick[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_act[c]  = int'(DDIV);
      m_sh[c]   = int'(DDIV);
      m_pend[c] = 1'b0;
      m_clk[c]  = 1'b0;
      m_tick[c] = 1'b0;
      m_due[c]  = k + int'(DDIV) + 1;
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), predict the next edge, wait for the next negedge.
  task automatic cyc(input bit we = 1'b0, input int sel = 0, input int val = 0, input bit sy = 1'b0);
    logic [11:0] e;
    bit hit;
    bit term;
    bus.div_we  = we;
    bus.div_sel = 2'(sel);
    bus.div_val = 8'(val);
    bus.sync    = sy;
    k++;
    for (int c = 0; c < N; c++) begin
      hit  = we && (sel == c);
      term = bus.en[c] && !sy && (k >= m_due[c]);
      if (hit) m_sh[c] = val;
      if (sy || !bus.en[c] || term) begin
        m_act[c]  = m_sh[c];
        m_pend[c] = 1'b0;
        m_due[c]  = k + m_act[c] + 1;
        m_tick[c] = term;
        m_clk[c]  = term && !bus.mode[c] && !m_clk[c];
      end else begin
        if (hit) m_pend[c] = 1'b1;
        m_tick[c] = 1'b0;
      end
    end
    for (int c = 0; c < N; c++) begin
      e[8+c] = m_pend[c];
      e[4+c] = m_clk[c];
      e[c]   = m_tick[c];
    end
    sb.push_back(e);
    @(negedge clkin);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pend4"},   32'(bus.pend),    32'd0);
    check({tag, "_clkout4"}, 32'(bus.clkout),  32'd0);
    check({tag, "_tick4"},   32'(bus.tick),    32'd0);
    check({tag, "_pend3"},   32'(bus3.pend),   32'd0);
    check({tag, "_clkout3"}, 32'(bus3.clkout), 32'd0);
    check({tag, "_tick3"},   32'(bus3.tick),   32'd0);
  endtask

  // Called at a negedge: reset lands between edges, outputs must drop before the next edge.
  task automatic async_reset();
    #1 rstn = 1'b0;
    #1 check_zero("rst_mid");
    bus.en     = '0;
    bus.div_we = 1'b0;
    bus.sync   = 1'b0;
    @(negedge clkin);
    @(negedge clkin);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(posedge clkin);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out4", {20'd0, bus.pend, bus.clkout, bus.tick}, {20'd0, e});
        check("out3", {23'd0, bus3.pend, bus3.clkout, bus3.tick},
              {23'd0, e[10:8], e[6:4], e[2:0]});
      end
    end
  end

  initial begin : stimulus
    bus.en      = '0;
    bus.mode    = '0;
    bus.sync    = 1'b0;
    bus.div_we  = 1'b0;
    bus.div_sel = '0;
    bus.div_val = '0;
    k = 0;

    #1 rstn = 1'b0;
    #1 check_zero("rst_init");
    @(negedge clkin);
    @(negedge clkin);
    rstn = 1'b1;
    model_reset();

    // Channel 0 toggling at the default divisor.
    bus.en   = 4'b0001;
    bus.mode = 4'b0000;
    repeat (20) cyc();

    // Channel 1 pulse mode, divisor 9 written mid-period.
    bus.en   = 4'b0010;
    bus.mode = 4'b0010;
    repeat (2) cyc();
    cyc(1'b1, 1, 9);
    repeat (35) cyc();

    // Channel 2 divisor 0: toggle then pulse.
    bus.en   = 4'b0100;
    bus.mode = 4'b0000;
    cyc(1'b1, 2, 0);
    repeat (10) cyc();
    bus.mode = 4'b0100;
    repeat (10) cyc();

    // Write landing exactly on channel 0's terminal count, then an out-of-range select for the 3-channel build.
    bus.en   = 4'b0101;
    bus.mode = 4'b0000;
    repeat (3) cyc();
    for (int n = 0; n < 50 && m_due[0] != k + 1; n++) cyc();
    cyc(1'b1, 0, 5);
    cyc(1'b1, 3, 7);
    repeat (20) cyc();

    // All channels running at mixed phases, equalised divisors, then a realign.
    bus.en = 4'b1111;
    cyc(1'b1, 0, 4);
    cyc(1'b1, 3, 4);
    repeat (3) cyc();
    cyc(1'b1, 1, 4);
    repeat (2) cyc();
    cyc(1'b1, 2, 4);
    repeat (7) cyc();
    cyc(1'b0, 0, 0, 1'b1);
    repeat (25) cyc();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) bus.en   = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bus.mode = 4'($urandom);
      if ($urandom_range(0, 49) == 0)     cyc(1'b0, 0, 0, 1'b1);
      else if ($urandom_range(0, 5) == 0) cyc(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
      else                                cyc();
    end

    // Leave a pending write and a high clock in flight, then reset mid-period.
    bus.en   = 4'b1111;
    bus.mode = 4'b0000;
    repeat (9) cyc();
    cyc(1'b1, 3, 200);
    cyc();
    async_reset();
    bus.en   = 4'b1111;
    bus.mode = 4'b0110;
    repeat (15) cyc();

    @(negedge clkin);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
